// File: rtl/philv_mem_pkg.sv
// Shared types and defaults for the PhilosophyV memory arbiter.
// Imported by the arbiter top and its winner-select helper.
package philv_mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int DEF_MEM_LATENCY    = 1;
  localparam int DEF_MAX_FETCH_WAIT = 4;

endpackage

// File: rtl/philv_mem_arb_pick.sv
// Winner selection between fetch and data requesters.
// Data wins ties unless fetch has waited MAX_FETCH_WAIT grants.
module philv_mem_arb_pick
  import philv_mem_pkg::*;
#(
  parameter int MAX_FETCH_WAIT = DEF_MAX_FETCH_WAIT,
  parameter int CW             = 3
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          pick_if,
  output logic          pick_dm
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_FETCH_WAIT);

  logic w_starved;

  assign w_starved = (starve_cnt == MAXC);
  assign pick_if   = if_req & (~dm_req | w_starved);
  assign pick_dm   = dm_req & ~pick_if;

endmodule

// File: rtl/philv_mem_arbiter.sv
// Single-port memory arbiter: fetch vs load/store, one access
// outstanding, data priority with bounded fetch starvation.
module philv_mem_arbiter
  import philv_mem_pkg::*;
#(
  parameter int N              = 32,
  parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
  parameter int MAX_FETCH_WAIT = DEF_MAX_FETCH_WAIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_rvalid,
  output logic [N-1:0] if_rdata,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic         dm_gnt,
  output logic         dm_rvalid,
  output logic [N-1:0] dm_rdata,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout
);

  localparam int CW = $clog2(MAX_FETCH_WAIT + 1);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_FETCH_WAIT);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [LW-1:0] LONE = LW'(1);
  localparam logic [LW-1:0] LLOAD = LW'(MEM_LATENCY);

  state_t        r_state;
  owner_t        r_owner;
  logic          r_we;
  logic [N-1:0]  r_addr;
  logic [LW-1:0] r_lat;
  logic [CW-1:0] r_starve;

  logic w_idle;
  logic w_pick_if;
  logic w_pick_dm;
  logic w_if_gnt;
  logic w_dm_gnt;
  logic w_last;

  philv_mem_arb_pick #(
    .MAX_FETCH_WAIT(MAX_FETCH_WAIT),
    .CW            (CW)
  ) u_pick (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .starve_cnt(r_starve),
    .pick_if   (w_pick_if),
    .pick_dm   (w_pick_dm)
  );

  // rst gates grants so outputs read 0 while reset is held
  assign w_idle   = (r_state == IDLE) & ~rst;
  assign w_if_gnt = w_idle & w_pick_if;
  assign w_dm_gnt = w_idle & w_pick_dm;
  assign w_last   = (r_state == WAIT) & (r_lat == LONE);

  assign if_gnt     = w_if_gnt;
  assign dm_gnt     = w_dm_gnt;
  assign mem_wr_ena = w_dm_gnt & dm_we;
  assign mem_din    = w_dm_gnt ? dm_wdata : '0;
  assign mem_addr   = w_if_gnt ? if_addr :
                      w_dm_gnt ? dm_addr : r_addr;

  assign if_rvalid = w_last & (r_owner == OWN_IF);
  assign dm_rvalid = w_last & (r_owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_dout : '0;
  assign dm_rdata  = (dm_rvalid & ~r_we) ? mem_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IF;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_lat    <= '0;
      r_starve <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_if_gnt | w_dm_gnt) begin
            r_state <= WAIT;
            r_owner <= w_dm_gnt ? OWN_DM : OWN_IF;
            r_we    <= w_dm_gnt & dm_we;
            r_addr  <= mem_addr;
            r_lat   <= LLOAD;
          end
          if (w_if_gnt | ~if_req)
            r_starve <= '0;
          else if (w_dm_gnt && r_starve != MAXC)
            r_starve <= r_starve + CONE;
        end
        WAIT: begin
          r_lat <= r_lat - LONE;
          if (r_lat == LONE)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_philv_mem_arbiter.sv
// Bench for philv_mem_arbiter: latency-1 and latency-3 instances,
// transaction-level model checked every cycle plus directed literals.
module tb_philv_mem_arbiter;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        if_req[2];
  logic [31:0] if_addr[2];
  logic        if_gnt[2];
  logic        if_rvalid[2];
  logic [31:0] if_rdata[2];
  logic        dm_req[2];
  logic        dm_we[2];
  logic [31:0] dm_addr[2];
  logic [31:0] dm_wdata[2];
  logic        dm_gnt[2];
  logic        dm_rvalid[2];
  logic [31:0] dm_rdata[2];
  logic        mem_wr_ena[2];
  logic [31:0] mem_addr[2];
  logic [31:0] mem_din[2];
  logic [31:0] mem_dout[2];

  int n_tests = 0;
  int n_fail  = 0;

  philv_mem_arbiter #(
    .N(32), .MEM_LATENCY(1), .MAX_FETCH_WAIT(MAXW)
  ) u0 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]),
    .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]),
    .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]),
    .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]),
    .dm_rdata(dm_rdata[0]),
    .mem_wr_ena(mem_wr_ena[0]), .mem_addr(mem_addr[0]),
    .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
  );

  philv_mem_arbiter #(
    .N(32), .MEM_LATENCY(3), .MAX_FETCH_WAIT(MAXW)
  ) u1 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]),
    .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]),
    .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]),
    .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]),
    .dm_rdata(dm_rdata[1]),
    .mem_wr_ena(mem_wr_ena[1]), .mem_addr(mem_addr[1]),
    .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
  );

  // synchronous-read memory per instance, read pipe of depth LAT
  logic [31:0] bmem[2][256];
  logic [31:0] pipe[2][3];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_wr_ena[k])
        bmem[k][mem_addr[k][9:2]] <= mem_din[k];
      pipe[k][0] <= bmem[k][mem_addr[k][9:2]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign mem_dout[0] = pipe[0][0];
  assign mem_dout[1] = pipe[1][2];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // transaction model: cycles left in the access, owner, contents
  int          busy[2];
  int          starve[2];
  bit          mdm[2];
  bit          mwe[2];
  logic [31:0] mad[2];
  logic [31:0] mmem[2][256];

  // 0 none, 1 fetch, 2 data
  function automatic int pick(int k);
    if (!if_req[k] && !dm_req[k]) return 0;
    if (if_req[k] && (!dm_req[k] || starve[k] == MAXW)) return 1;
    return 2;
  endfunction

  task automatic chk(string nm, int k,
                     logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %h want %h",
               nm, k, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        busy[k]   = 0;
        starve[k] = 0;
      end else if (busy[k] > 0) begin
        busy[k]--;
      end else begin
        int p;
        p = pick(k);
        if (p != 0) begin
          busy[k] = lat_of(k);
          mdm[k]  = (p == 2);
          mwe[k]  = (p == 2) && dm_we[k];
          mad[k]  = (p == 2) ? dm_addr[k] : if_addr[k];
          if (mwe[k]) mmem[k][mad[k][9:2]] = dm_wdata[k];
        end
        if (p == 1 || !if_req[k]) starve[k] = 0;
        else if (p == 2 && starve[k] < MAXW) starve[k]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic        eig, edg, eiv, edv, ewe;
      logic [31:0] eir, edr, ead, edin;
      bit          ca, cd;
      eig = 0; edg = 0; eiv = 0; edv = 0; ewe = 0;
      eir = 0; edr = 0; ead = 0; edin = 0;
      ca = 0; cd = 0;
      if (rst[k]) begin
        ca = 1; cd = 1;
      end else if (busy[k] > 0) begin
        ca  = 1;
        ead = mad[k];
        if (busy[k] == 1) begin
          if (mdm[k]) begin
            edv = 1;
            edr = mwe[k] ? 32'h0 : mmem[k][mad[k][9:2]];
          end else begin
            eiv = 1;
            eir = mmem[k][mad[k][9:2]];
          end
        end
      end else begin
        int p;
        p = pick(k);
        if (p == 1) begin
          eig = 1; ca = 1; ead = if_addr[k];
        end else if (p == 2) begin
          edg = 1; ca = 1; cd = 1;
          ead = dm_addr[k]; ewe = dm_we[k];
          edin = dm_wdata[k];
        end
      end
      chk("if_gnt", k, if_gnt[k], eig);
      chk("dm_gnt", k, dm_gnt[k], edg);
      chk("if_rvalid", k, if_rvalid[k], eiv);
      chk("dm_rvalid", k, dm_rvalid[k], edv);
      chk("if_rdata", k, if_rdata[k], eir);
      chk("dm_rdata", k, dm_rdata[k], edr);
      chk("mem_wr_ena", k, mem_wr_ena[k], ewe);
      if (ca) chk("mem_addr", k, mem_addr[k], ead);
      if (cd) chk("mem_din", k, mem_din[k], edin);
    end
  end

  string seq;
  always @(negedge clk) begin
    if (!rst[0]) begin
      if (dm_gnt[0]) seq = {seq, "D"};
      if (if_gnt[0]) seq = {seq, "I"};
    end
  end

  task automatic seq_chk(string nm, string exp);
    n_tests++;
    if (seq != exp) begin
      n_fail++;
      $display("FAIL %s: got %s want %s", nm, seq, exp);
    end
  endtask

  task automatic timeout(string nm, int k);
    n_tests++;
    n_fail++;
    $display("FAIL %s[%0d] timeout @%0t", nm, k, $time);
  endtask

  // entered and left at posedge+1
  task automatic access(input int k, input bit dm,
                        input bit we, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] d,
                        output int lat, output int wc);
    logic g;
    d = 0; lat = 0; wc = 0;
    if (dm) begin
      dm_req[k] = 1; dm_we[k] = we;
      dm_addr[k] = a; dm_wdata[k] = wd;
    end else begin
      if_req[k] = 1; if_addr[k] = a;
    end
    forever begin
      @(negedge clk);
      g = dm ? dm_gnt[k] : if_gnt[k];
      if (g) break;
      wc++;
      if (wc > 50) begin
        timeout("gnt", k);
        if (dm) dm_req[k] = 0; else if_req[k] = 0;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    if (dm) dm_req[k] = 0; else if_req[k] = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (dm ? dm_rvalid[k] : if_rvalid[k]) begin
        d = dm ? dm_rdata[k] : if_rdata[k];
        break;
      end
      if (lat > 20) begin
        timeout("rvalid", k);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    int lat, wc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        bmem[k][i] = 32'h1000_0000 + i;
        mmem[k][i] = 32'h1000_0000 + i;
      end
      bmem[k][0] = 32'h0050_0093;
      mmem[k][0] = 32'h0050_0093;
      for (int j = 0; j < 3; j++) pipe[k][j] = 0;
      busy[k] = 0; starve[k] = 0;
      mdm[k] = 0; mwe[k] = 0; mad[k] = 0;
      rst[k] = 1;
      if_req[k] = 0; if_addr[k] = 0;
      dm_req[k] = 0; dm_we[k] = 0;
      dm_addr[k] = 0; dm_wdata[k] = 0;
    end
    seq = "";
    if_req[0] = 1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 0; rst[1] = 0;

    access(0, 0, 0, 32'h0, 32'h0, d, lat, wc);
    chk("t1_wait", 0, wc, 0);
    chk("t1_lat", 0, lat, 1);
    chk("t1_data", 0, d, 32'h0050_0093);

    access(0, 1, 1, 32'h40, 32'hDEAD_BEEF, d, lat, wc);
    chk("t2_wlat", 0, lat, 1);
    chk("t2_ack", 0, d, 32'h0);
    access(0, 1, 0, 32'h40, 32'h0, d, lat, wc);
    chk("t2_rd", 0, d, 32'hDEAD_BEEF);

    seq = "";
    if_addr[0] = 32'h4; dm_addr[0] = 32'h8; dm_we[0] = 0;
    if_req[0] = 1; dm_req[0] = 1;
    repeat (20) @(posedge clk);
    #1;
    if_req[0] = 0; dm_req[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    seq_chk("t3_order", "DDDDIDDDDI");

    seq = "";
    if_req[0] = 1; dm_req[0] = 1;
    repeat (6) @(posedge clk);
    #1;
    if_req[0] = 0;
    @(posedge clk); #1;
    if_req[0] = 1;
    repeat (11) @(posedge clk);
    #1;
    if_req[0] = 0; dm_req[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    seq_chk("t6_order", "DDDDDDDDI");

    if_req[1] = 1; if_addr[1] = 32'h14;
    access(1, 1, 0, 32'h10, 32'h0, d, lat, wc);
    chk("t4_dwait", 1, wc, 0);
    chk("t4_dlat", 1, lat, 3);
    chk("t4_ddata", 1, d, 32'h1000_0004);
    access(1, 0, 0, 32'h14, 32'h0, d, lat, wc);
    chk("t4_iwait", 1, wc, 0);
    chk("t4_ilat", 1, lat, 3);
    chk("t4_idata", 1, d, 32'h1000_0005);

    if_req[1] = 1; if_addr[1] = 32'h8;
    @(negedge clk);
    chk("t5_gnt", 1, if_gnt[1], 1'b1);
    @(posedge clk); #1;
    rst[1] = 1;
    #1;
    chk("t5_rst_gnt", 1, if_gnt[1], 1'b0);
    chk("t5_rst_rv", 1, if_rvalid[1], 1'b0);
    chk("t5_rst_addr", 1, mem_addr[1], 32'h0);
    chk("t5_rst_rd", 1, if_rdata[1], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 0;
    @(negedge clk);
    chk("t5_regnt", 1, if_gnt[1], 1'b1);
    @(posedge clk); #1;
    if_req[1] = 0;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
